// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Purpose  : Shared definitions for the systolic mat-vec driver: FSM state
//            encoding, default array/data/accumulator sizes and the helper
//            that sizes row/column index fields.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int c_DEF_ARRAY_SIZE = 4;
    localparam int c_DEF_DATA_WIDTH = 16;
    localparam int c_DEF_ACC_WIDTH  = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        ACT   = 3'd3,
        WAIT  = 3'd4,
        OUT   = 3'd5
    } drv_state_t;

    // Index width for an N-wide dimension; never narrower than one bit so a
    // 1x1 array still has a legal row/col field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_matvec_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_matvec_driver_if
// Purpose  : Bundles the job request, weight-memory read port, systolic array
//            load/issue/result ports and the result handshake.
//            master : driver side (systolic_matvec_driver)
//            slave  : environment side (requester, memory, array, consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface systolic_matvec_driver_if
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = c_DEF_ARRAY_SIZE,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = c_DEF_ACC_WIDTH,
    parameter int ADDR_W     = 12
);
    localparam int c_IDX_W = idx_width(ARRAY_SIZE);

    logic                             start;
    logic [ADDR_W-1:0]                w_base;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] act_vec;
    logic                             busy;
    logic                             mem_rd_en;
    logic [ADDR_W-1:0]                mem_rd_addr;
    logic [DATA_WIDTH-1:0]            mem_rd_data;
    logic                             sa_load_weight;
    logic [c_IDX_W-1:0]               sa_weight_row;
    logic [c_IDX_W-1:0]               sa_weight_col;
    logic [DATA_WIDTH-1:0]            sa_weight_data;
    logic                             sa_valid_in;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] sa_act_in;
    logic                             sa_valid_out;
    logic [ARRAY_SIZE*ACC_WIDTH-1:0]  sa_result_in;
    logic                             res_valid;
    logic                             res_ready;
    logic [ARRAY_SIZE*ACC_WIDTH-1:0]  res_data;
    logic                             err;

    modport master (
        input  start, w_base, act_vec, mem_rd_data, sa_valid_out, sa_result_in, res_ready,
        output busy, mem_rd_en, mem_rd_addr, sa_load_weight, sa_weight_row, sa_weight_col,
               sa_weight_data, sa_valid_in, sa_act_in, res_valid, res_data, err
    );

    modport slave (
        output start, w_base, act_vec, mem_rd_data, sa_valid_out, sa_result_in, res_ready,
        input  busy, mem_rd_en, mem_rd_addr, sa_load_weight, sa_weight_row, sa_weight_col,
               sa_weight_data, sa_valid_in, sa_act_in, res_valid, res_data, err
    );

endinterface
`default_nettype wire

// File: rtl/systolic_drv_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : systolic_drv_addr_gen
// Purpose  : Row-major weight tile walker. Produces the weight-memory read
//            address base + r*N + c (wrapping modulo 2^ADDR_W) and a copy of
//            (r, c) delayed by one cycle to line up with the memory's fixed
//            one-cycle read latency.
// Ports    : i_load   - latch i_base and restart at (0,0)
//            i_fetch  - a read is issued this cycle; advance (r, c)
//            o_rd_addr- read address (0 when not fetching)
//            o_last   - current read is cell (N-1, N-1)
//            o_wr_*   - array write strobe/indices for the data returning now
// Revision : 1.0 - initial release
// ============================================================================
module systolic_drv_addr_gen
    import systolic_pkg::*;
#(
    parameter  int ARRAY_SIZE = c_DEF_ARRAY_SIZE,
    parameter  int ADDR_W     = 12,
    localparam int IDX_W      = idx_width(ARRAY_SIZE)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic [ADDR_W-1:0] i_base,
    input  wire logic              i_fetch,
    output logic [ADDR_W-1:0]      o_rd_addr,
    output logic                   o_last,
    output logic                   o_wr_en,
    output logic [IDX_W-1:0]       o_wr_row,
    output logic [IDX_W-1:0]       o_wr_col
);
    localparam logic [IDX_W-1:0]  c_LAST   = IDX_W'(ARRAY_SIZE - 1);
    localparam logic [ADDR_W-1:0] c_STRIDE = ADDR_W'(ARRAY_SIZE);

    logic [ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]  r_row;
    logic [IDX_W-1:0]  r_col;
    logic              r_wr_en;
    logic [IDX_W-1:0]  r_wr_row;
    logic [IDX_W-1:0]  r_wr_col;
    logic [ADDR_W-1:0] w_addr;

    // Truncation to ADDR_W bits gives the required modulo-2^ADDR_W wrap.
    assign w_addr = r_base + ADDR_W'(r_row) * c_STRIDE + ADDR_W'(r_col);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_wr_en  <= 1'b0;
            r_wr_row <= '0;
            r_wr_col <= '0;
        end else begin
            r_wr_en  <= i_fetch;
            r_wr_row <= r_row;
            r_wr_col <= r_col;
            if (i_load) begin
                r_base <= i_base;
                r_row  <= '0;
                r_col  <= '0;
            end else if (i_fetch) begin
                if (r_col == c_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign o_rd_addr = i_fetch ? w_addr : '0;
    assign o_last    = (r_row == c_LAST) && (r_col == c_LAST);
    assign o_wr_en   = r_wr_en;
    assign o_wr_row  = r_wr_row;
    assign o_wr_col  = r_wr_col;

endmodule
`default_nettype wire

// File: rtl/systolic_matvec_driver.sv
`default_nettype none
// ============================================================================
// Module   : systolic_matvec_driver
// Purpose  : Sequences one matrix-vector job on an N x N systolic array:
//            loads all N*N weights from memory, issues the activation vector
//            once, captures the array result and presents it on a
//            valid/ready handshake.
// Ports    : clk, rst (synchronous, active-high)
//            bus_if (master) - job request, weight memory read port, array
//                              load/issue/result ports, result handshake, err
// Config   : SYSTOLIC_DRV_TIMEOUT_EN - when defined, a watchdog aborts WAIT
//            after TIMEOUT_CYC cycles and pulses err; otherwise err is 0.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_matvec_driver
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE  = c_DEF_ARRAY_SIZE,
    parameter int DATA_WIDTH  = c_DEF_DATA_WIDTH,
    parameter int ACC_WIDTH   = c_DEF_ACC_WIDTH,
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 64
) (
    input  wire logic                clk,
    input  wire logic                rst,
    systolic_matvec_driver_if.master bus_if
);
    localparam int c_IDX_W = idx_width(ARRAY_SIZE);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    drv_state_t                       r_state;
    drv_state_t                       w_next;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] r_act;
    logic [ARRAY_SIZE*ACC_WIDTH-1:0]  r_res;
    logic                             w_start_job;
    logic                             w_fetch;
    logic                             w_valid_in;
    logic                             w_res_valid;
    logic                             w_capture;
    logic                             w_last;
    logic                             w_wr_en;
    logic [c_IDX_W-1:0]               w_wr_row;
    logic [c_IDX_W-1:0]               w_wr_col;

`ifdef SYSTOLIC_DRV_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_TO_W-1:0] r_wait_cnt;
    logic              r_err;
    logic              w_timeout;

    // Fires on the TIMEOUT_CYC-th WAIT cycle without a result.
    assign w_timeout = (r_state == WAIT) && !bus_if.sa_valid_out &&
                       (r_wait_cnt == c_TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if ((r_state == WAIT) && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign bus_if.err = r_err;
`else
    assign bus_if.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_act   <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_job) begin
                r_act <= bus_if.act_vec;
            end
            if (w_capture) begin
                r_res <= bus_if.sa_result_in;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start_job = 1'b0;
        w_fetch     = 1'b0;
        w_valid_in  = 1'b0;
        w_res_valid = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus_if.start) begin
                    w_start_job = 1'b1;
                    w_next      = FETCH;
                end
            end
            FETCH: begin
                w_fetch = 1'b1;
                if (w_last) begin
                    w_next = DRAIN;
                end
            end
            // One idle cycle lets the final read's data reach the array.
            DRAIN: w_next = ACT;
            ACT: begin
                w_valid_in = 1'b1;
                w_next     = WAIT;
            end
            WAIT: begin
                if (bus_if.sa_valid_out) begin
                    w_capture = 1'b1;
                    w_next    = OUT;
                end
`ifdef SYSTOLIC_DRV_TIMEOUT_EN
                else if (w_timeout) begin
                    w_next = IDLE;
                end
`endif
            end
            OUT: begin
                w_res_valid = 1'b1;
                if (bus_if.res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    systolic_drv_addr_gen #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_start_job),
        .i_base    (bus_if.w_base),
        .i_fetch   (w_fetch),
        .o_rd_addr (bus_if.mem_rd_addr),
        .o_last    (w_last),
        .o_wr_en   (w_wr_en),
        .o_wr_row  (w_wr_row),
        .o_wr_col  (w_wr_col)
    );

    assign bus_if.busy           = (r_state != IDLE);
    assign bus_if.mem_rd_en      = w_fetch;
    assign bus_if.sa_load_weight = w_wr_en;
    assign bus_if.sa_weight_row  = w_wr_row;
    assign bus_if.sa_weight_col  = w_wr_col;
    // Gated so the write bus reads 0 whenever no write is in flight.
    assign bus_if.sa_weight_data = w_wr_en ? bus_if.mem_rd_data : '0;
    assign bus_if.sa_valid_in    = w_valid_in;
    assign bus_if.sa_act_in      = w_valid_in ? r_act : '0;
    assign bus_if.res_valid      = w_res_valid;
    assign bus_if.res_data       = r_res;

endmodule
`default_nettype wire

// File: doc/systolic_matvec_driver.md
SYSTOLIC_MATVEC_DRIVER -- requirements
Module: systolic_matvec_driver

Interface
REQ-001 Parameters: ARRAY_SIZE, default 4, array dimension N; DATA_WIDTH, default 16, weight/activation width DW; ACC_WIDTH, default 32, result lane width AW; ADDR_W, default 12, weight memory address width; TIMEOUT_CYC, default 64, result watchdog limit in cycles.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  job request pulse, sampled only in IDLE.
REQ-005 w_base  in  ADDR_W  base address of row-major N x N weight tile.
REQ-006 act_vec  in  N*DW  activation vector; lane i at bits [i*DW +: DW].
REQ-007 busy  out  1  high whenever state is not IDLE.
REQ-008 mem_rd_en  out  1; mem_rd_addr  out  ADDR_W; mem_rd_data  in  DW  weight memory read port with fixed 1-cycle read latency.
REQ-009 sa_load_weight  out  1; sa_weight_row, sa_weight_col  out  $clog2(N); sa_weight_data  out  DW  weight write port to the systolic array.
REQ-010 sa_valid_in  out  1; sa_act_in  out  N*DW  activation issue to the array.
REQ-011 sa_valid_out  in  1; sa_result_in  in  N*AW  array result, lane j at bits [j*AW +: AW].
REQ-012 res_valid  out  1; res_ready  in  1; res_data  out  N*AW  result handshake to consumer.
REQ-013 err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-014 The FSM SHALL use states IDLE, FETCH, DRAIN, ACT, WAIT, OUT.
REQ-015 IDLE: start=1 latches w_base and act_vec and moves to FETCH; start outside IDLE is ignored.
REQ-016 FETCH: mem_rd_en=1 for exactly N*N consecutive cycles, mem_rd_addr = w_base + r*N + c, with r-major, c-minor order from (0,0) to (N-1,N-1); the address wraps modulo 2^ADDR_W.
REQ-017 Each read's data SHALL be written one cycle after issue: sa_load_weight=1, sa_weight_row=r, sa_weight_col=c, sa_weight_data=mem_rd_data; DRAIN covers the final write.
REQ-018 All N*N cells SHALL be written every job, zero values included, so stale weights never survive.
REQ-019 ACT: sa_valid_in=1 for exactly one cycle with sa_act_in = latched act_vec; sa_act_in SHALL be 0 whenever sa_valid_in=0.
REQ-020 WAIT: on the first cycle sa_valid_out=1, sa_result_in SHALL be captured into res_data and the FSM moves to OUT.
REQ-021 OUT: res_valid=1; res_data is held stable until res_valid&&res_ready, after which the FSM enters IDLE and res_valid drops the next cycle.
REQ-022 Timing with array latency 1: start sampled at cycle 0; mem_rd_en cycles 1..N*N; sa_load_weight cycles 2..N*N+1; sa_valid_in cycle N*N+2; res_valid from cycle N*N+4 (20 for N=4).
REQ-023 sa_valid_out outside WAIT SHALL be ignored.

Reset
REQ-024 On rst, the block SHALL enter IDLE and SHALL drive all outputs to 0: busy, mem_rd_en, mem_rd_addr, sa_load_weight, row/col, sa_weight_data, sa_valid_in, sa_act_in, res_valid, res_data, err.
REQ-025 rst mid-job SHALL abort at the next edge with no further writes or valid_in and no result; partially loaded array weights are acceptable.
REQ-026 rst has priority over start and res_ready in the same cycle.

Configuration
REQ-027 Macro SYSTOLIC_DRV_TIMEOUT_EN defined: a counter runs in WAIT; after TIMEOUT_CYC cycles without sa_valid_out, err=1 for one cycle, the FSM returns to IDLE and res_valid is never asserted.
REQ-028 SYSTOLIC_DRV_TIMEOUT_EN undefined: WAIT is unbounded, err is tied to 0, and no counter logic exists.

Structure
REQ-029 Shared package systolic_pkg SHALL hold the FSM state encoding, default ARRAY_SIZE/DATA_WIDTH/ACC_WIDTH constants, and the index-width helper.
REQ-030 One sub-module, systolic_drv_addr_gen, SHALL hold the row/col counters, address generation and the one-cycle write-index delay; the FSM stays in the top.

Verification
REQ-031 Memory at base 0x010 holds diag(1,2,3,4) (others 0); act=[10,20,30,40]; 1-cycle array model -> res_data=[10,40,90,160] with res_valid at cycle 20.
REQ-032 Memory holds 1..16 row-major; act=[1,1,1,1] -> [28,32,36,40]; then act=[0,1,0,0] on a second job -> [5,6,7,8], and 16 writes are observed again.
REQ-033 Hold res_ready=0 for 5 cycles in OUT -> res_data stable, res_valid stays 1, start pulses are ignored, busy=1.
REQ-034 Assert rst at cycle 8 of FETCH -> next cycle all outputs 0, no sa_valid_in; a new start completes correctly.
REQ-035 w_base=0xFFE -> addresses 0xFFE,0xFFF,0x000,... wrap correctly.
REQ-036 With SYSTOLIC_DRV_TIMEOUT_EN and the array model never asserting sa_valid_out -> err pulses exactly once after 64 WAIT cycles, busy drops, and res_valid stays 0.
